// File: rtl/des_pkg.sv
// Shared DES definitions: block widths, initial/final permutation tables
// and the loader FSM state encoding.
package des_pkg;

  localparam int DES_BLOCK_W = 64;
  localparam int DES_HALF_W  = 32;

  // Output bit i (1..64) takes input bit IP_TABLE[i]; bit 1 is the MSB.
  localparam int IP_TABLE [1:64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  // Final permutation used by the output stage; the inverse of IP_TABLE.
  localparam int FP_TABLE [1:64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } load_state_t;

endpackage

// File: rtl/des_ip_perm.sv
// Combinational DES initial permutation over a [1:64] block (bit 1 = MSB).
module des_ip_perm
  import des_pkg::*;
(
  input  logic [1:DES_BLOCK_W] data_in,
  output logic [1:DES_BLOCK_W] data_out
);

  for (genvar i = 1; i <= DES_BLOCK_W; i++) begin : g_bit
    assign data_out[i] = data_in[IP_TABLE[i]];
  end

endmodule

// File: rtl/des_ip_loader.sv
// Collects eight bytes into a DES block, applies IP and holds L0/R0 for the
// round engine until it is taken.
module des_ip_loader
  import des_pkg::*;
#(
  parameter int BYTE_ORDER = 0
)
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:8]          in_byte,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:DES_HALF_W] out_l,
  output logic [1:DES_HALF_W] out_r,
  output logic [2:0]          byte_cnt
);

  load_state_t state, state_next;

  // Only the seven earlier bytes need storage; the eighth comes straight from in_byte.
  logic [1:DES_BLOCK_W-8] shreg, shreg_next;
  logic [1:DES_BLOCK_W]   block_next, perm_out;
  logic                   byte_acc, out_load;

  if (BYTE_ORDER == 0) begin : g_msb_first
    assign block_next = {shreg, in_byte};
    assign shreg_next = block_next[9:DES_BLOCK_W];
  end else begin : g_lsb_first
    assign block_next = {in_byte, shreg};
    assign shreg_next = block_next[1:DES_BLOCK_W-8];
  end

  des_ip_perm u_perm (
    .data_in  (block_next),
    .data_out (perm_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    byte_acc   = 1'b0;
    out_load   = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          byte_acc = 1'b1;
          if (byte_cnt == 3'd7) begin
            out_load   = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
    // A flush wins over any handshake seen on the same edge.
    if (clr) begin
      state_next = COLLECT;
      byte_acc   = 1'b0;
      out_load   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      byte_cnt  <= 3'd0;
      out_valid <= 1'b0;
      out_l     <= '0;
      out_r     <= '0;
    end else if (clr) begin
      byte_cnt  <= 3'd0;
      out_valid <= 1'b0;
    end else begin
      if (byte_acc) begin
        shreg    <= shreg_next;
        byte_cnt <= byte_cnt + 3'd1;
      end
      if (out_load) begin
        out_l     <= perm_out[1:DES_HALF_W];
        out_r     <= perm_out[DES_HALF_W+1:DES_BLOCK_W];
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_des_ip_loader.sv
// Scoreboard bench for des_ip_loader: one MSB-first and one LSB-first instance
// driven with directed and random blocks, outputs checked against an IP model.
module tb_des_ip_loader;
  import des_pkg::*;

  typedef struct packed {
    logic [63:0] blk;
    logic [63:0] exp;
  } sb_entry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic        clr       [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  in_byte   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_l     [2];
  logic [31:0] out_r     [2];
  logic [2:0]  byte_cnt  [2];

  int rdy_mode [2] = '{0, 0};
  int errors = 0;
  int checks = 0;
  sb_entry_t sb0 [$];
  sb_entry_t sb1 [$];

  des_ip_loader #(.BYTE_ORDER(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .clr(clr[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_byte(in_byte[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_l(out_l[0]), .out_r(out_r[0]), .byte_cnt(byte_cnt[0])
  );

  des_ip_loader #(.BYTE_ORDER(1)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .clr(clr[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_byte(in_byte[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_l(out_l[1]), .out_r(out_r[1]), .byte_cnt(byte_cnt[1])
  );

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // IP from its row structure: rows 1-4 start at 58,60,62,64; rows 5-8 at 57,59,61,63; step -8.
  function automatic logic [63:0] ipModel(input logic [63:0] x);
    logic [63:0] y;
    int row, col, src;
    for (int i = 1; i <= 64; i++) begin
      row = (i - 1) / 8;
      col = (i - 1) % 8;
      src = (row < 4) ? (58 + 2 * row - 8 * col) : (57 + 2 * (row - 4) - 8 * col);
      y[64 - i] = x[64 - src];
    end
    return y;
  endfunction

  function automatic logic [63:0] fpApply(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 1; i <= 64; i++) y[64 - i] = x[64 - FP_TABLE[i]];
    return y;
  endfunction

  function automatic logic [7:0] byteOf(input int d, input logic [63:0] blk, input int k);
    if (d == 0) return blk[63 - 8 * k -: 8];
    return blk[8 * k +: 8];
  endfunction

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      case (rdy_mode[d])
        0:       out_ready[d] = 1'b0;
        1:       out_ready[d] = 1'b1;
        default: out_ready[d] = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  task automatic popAndCompare(input int d);
    sb_entry_t e;
    int n;
    logic [63:0] got;
    n = (d == 0) ? sb0.size() : sb1.size();
    checkOutput("sb_nonempty", 64'(n != 0), 64'd1);
    if (n != 0) begin
      if (d == 0) e = sb0.pop_front();
      else        e = sb1.pop_front();
      got = {out_l[d], out_r[d]};
      checkOutput((d == 0) ? "ip_out_bo0" : "ip_out_bo1", got, e.exp);
      checkOutput("fp_roundtrip", fpApply(got), e.blk);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n[d] === 1'b1 && clr[d] === 1'b0 && out_valid[d] === 1'b1 && out_ready[d] === 1'b1)
        popAndCompare(d);
    end
  end

  // Entered and left at posedge+1; the byte is consumed on the edge where in_ready was high.
  task automatic sendByte(input int d, input logic [7:0] b, input int maxGap);
    int n;
    logic rdy;
    in_valid[d] = 1'b0;
    repeat ($urandom_range(0, maxGap)) begin
      @(posedge clk);
      #1;
    end
    in_valid[d] = 1'b1;
    in_byte[d]  = b;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = in_ready[d];
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 300) begin
        checkOutput("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic applyStimulus(input int d, input logic [63:0] blk, input int maxGap);
    sb_entry_t e;
    e.blk = blk;
    e.exp = ipModel(blk);
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    for (int k = 0; k < 8; k++) sendByte(d, byteOf(d, blk, k), maxGap);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (((d == 0) ? sb0.size() : sb1.size()) != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain", 64'((d == 0) ? sb0.size() : sb1.size()), 64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] blk;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1; clr[d] = 1'b0; in_valid[d] = 1'b0; in_byte[d] = 8'h00;
    end
    #2;
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    #10;
    checkOutput("rst_out_valid", 64'(out_valid[0]), 64'd0);
    checkOutput("rst_out_lr", {out_l[0], out_r[0]}, 64'd0);
    checkOutput("rst_byte_cnt", 64'(byte_cnt[0]), 64'd0);
    #10;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready[0]), 64'd1);

    // Known vector, MSB-first, held to observe latency and backpressure.
    applyStimulus(0, 64'h0123456789ABCDEF, 0);
    checkOutput("t1_valid_latency", 64'(out_valid[0]), 64'd1);
    checkOutput("t1_in_ready_low", 64'(in_ready[0]), 64'd0);
    checkOutput("t1_out_l", 64'(out_l[0]), 64'h00000000CC00CCFF);
    checkOutput("t1_out_r", 64'(out_r[0]), 64'h00000000F0AAF0AA);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t1_hold_ready", 64'(in_ready[0]), 64'd0);
    rdy_mode[0] = 1;
    drain(0);

    // Single input bit 1 must land on output bit 40.
    rdy_mode[0] = 0;
    applyStimulus(0, 64'h8000000000000000, 0);
    checkOutput("t2_out_l", 64'(out_l[0]), 64'h0000000000000000);
    checkOutput("t2_out_r", 64'(out_r[0]), 64'h0000000001000000);
    rdy_mode[0] = 1;
    drain(0);

    // LSB-first instance, bytes sent EF CD .. 01.
    rst_n[1] = 1'b1;
    applyStimulus(1, 64'h0123456789ABCDEF, 0);
    checkOutput("t3_out_l", 64'(out_l[1]), 64'h00000000CC00CCFF);
    checkOutput("t3_out_r", 64'(out_r[1]), 64'h00000000F0AAF0AA);
    rdy_mode[1] = 1;
    drain(1);

    // Backpressure with in_valid asserted: nothing consumed, outputs stable.
    rdy_mode[0] = 0;
    blk = {$urandom, $urandom};
    applyStimulus(0, blk, 0);
    in_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_byte[0] = 8'($urandom);
      @(posedge clk);
      #1;
      checkOutput("t4_valid", 64'(out_valid[0]), 64'd1);
      checkOutput("t4_in_ready", 64'(in_ready[0]), 64'd0);
      checkOutput("t4_byte_cnt", 64'(byte_cnt[0]), 64'd0);
      checkOutput("t4_stable", {out_l[0], out_r[0]}, ipModel(blk));
    end
    in_valid[0] = 1'b0;
    rdy_mode[0] = 1;
    drain(0);
    applyStimulus(0, 64'hFFFFFFFFFFFFFFFF, 0);
    drain(0);

    // Partial block flushed by clr together with a 4th byte.
    blk = {$urandom, $urandom};
    for (int k = 0; k < 3; k++) sendByte(0, byteOf(0, blk, k), 0);
    checkOutput("t5_partial_cnt", 64'(byte_cnt[0]), 64'd3);
    clr[0] = 1'b1;
    in_valid[0] = 1'b1;
    in_byte[0] = 8'hA5;
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    in_valid[0] = 1'b0;
    checkOutput("t5_clr_cnt", 64'(byte_cnt[0]), 64'd0);
    applyStimulus(0, 64'h13579BDF02468ACE, 0);
    drain(0);

    // Asynchronous reset in the middle of a cycle while holding a block.
    rdy_mode[0] = 0;
    applyStimulus(0, {$urandom, $urandom}, 0);
    @(posedge clk);
    #3;
    rst_n[0] = 1'b0;
    #1;
    checkOutput("t6_async_valid", 64'(out_valid[0]), 64'd0);
    checkOutput("t6_async_lr", {out_l[0], out_r[0]}, 64'd0);
    checkOutput("t6_async_cnt", 64'(byte_cnt[0]), 64'd0);
    sb0.delete();
    #10;
    rst_n[0] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6_in_ready", 64'(in_ready[0]), 64'd1);
    checkOutput("t6_valid_after", 64'(out_valid[0]), 64'd0);

    // Random traffic on both instances with random gaps and backpressure.
    rdy_mode[0] = 2;
    rdy_mode[1] = 2;
    fork
      begin
        for (int b = 0; b < 1000; b++) applyStimulus(0, {$urandom, $urandom}, 1);
      end
      begin
        for (int b = 0; b < 200; b++) applyStimulus(1, {$urandom, $urandom}, 2);
      end
    join
    rdy_mode[0] = 1;
    rdy_mode[1] = 1;
    drain(0);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/des_ip_loader.md
Name: des_ip_loader

Overview:
- Input-side counterpart to the DES final-permutation stage.
- Collects a 64-bit plaintext/ciphertext block as eight bytes over a valid/ready byte stream.
- Applies the DES initial permutation (IP) and presents the block as L0/R0 halves to the round engine over a valid/ready handshake.
- Sits between the host byte interface and the 16-round core.

Parameters:
- BYTE_ORDER, 0, 0: first accepted byte fills bits [1:8] (MSB-first); 1: first accepted byte fills bits [57:64].

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush of any partial or held block
- in_valid  in  1  in_byte is valid
- in_ready  out  1  loader can accept a byte
- in_byte  in  [1:8]  byte data; bit 1 = MSB
- out_valid  out  1  out_l/out_r hold a permuted block
- out_ready  in  1  round engine accepts the block
- out_l  out  [1:32]  IP output bits 1..32 (L0)
- out_r  out  [1:32]  IP output bits 33..64 (R0)
- byte_cnt  out  3  bytes collected so far in the current block

Behaviour:
- Bit numbering is [1:64] throughout; bit 1 = MSB.
- Reset (rst_n low, asynchronous):
  - state = COLLECT, byte_cnt = 0, shift register = 0.
  - out_valid = 0, out_l = 0, out_r = 0.
  - in_ready becomes 1 the first cycle after rst_n deasserts.
- FSM states: COLLECT, HOLD.
- COLLECT:
  - in_ready = 1.
  - A byte is accepted on a rising edge where in_valid & in_ready; it is written into byte slot byte_cnt per BYTE_ORDER, and byte_cnt increments.
  - On acceptance of the byte with byte_cnt = 7:
    - IP is applied combinationally to the assembled 64 bits (including that byte) and registered into out_l/out_r at the same edge.
    - out_valid <= 1, byte_cnt wraps to 0, state <= HOLD.
  - Latency: out_valid is high the cycle after the 8th byte handshake.
- HOLD:
  - in_ready = 0. out_l/out_r and out_valid are stable until the handshake.
  - On out_valid & out_ready: out_valid <= 0, state <= COLLECT.
  - Data registers keep their last value; they are not cleared.
  - No same-cycle byte acceptance on the release edge, so minimum block period = 9 cycles.
- in_valid while in_ready = 0 is ignored; the byte is not consumed.
- clr (synchronous, highest priority after reset):
  - At the edge: byte_cnt <= 0, out_valid <= 0, state <= COLLECT.
  - A byte or output handshake coincident with clr is discarded.
- IP table (output bit i takes input bit, i = 1..64):
  - 58 50 42 34 26 18 10 2
  - 60 52 44 36 28 20 12 4
  - 62 54 46 38 30 22 14 6
  - 64 56 48 40 32 24 16 8
  - 57 49 41 33 25 17 9 1
  - 59 51 43 35 27 19 11 3
  - 61 53 45 37 29 21 13 5
  - 63 55 47 39 31 23 15 7
- IP composed with the existing final permutation is the identity on 64 bits.
- Reset asserted mid-block: partial bytes are lost; no output is produced for that block.

Decomposition:
- Shared package des_pkg:
  - DES_BLOCK_W = 64, DES_HALF_W = 32.
  - IP table as a constant array (indexed 1..64), alongside the final-permutation table.
  - FSM state encoding: COLLECT = 1'b0, HOLD = 1'b1.
- One combinational sub-module, des_ip_perm (data_in [1:64] -> data_out [1:64]), instantiated once.
- FSM, byte assembly and output registers live in des_ip_loader.

Test Plan:
- BYTE_ORDER=0; send 01 23 45 67 89 AB CD EF back-to-back -> out_valid high the cycle after the 8th byte, out_l=CC00CCFF, out_r=F0AAF0AA; in_ready=0 until out_ready.
- BYTE_ORDER=0; send 80 00 00 00 00 00 00 00 -> out_l=00000000, out_r=01000000 (input bit 1 lands at output bit 40).
- BYTE_ORDER=1; send EF CD AB 89 67 45 23 01 -> out_l=CC00CCFF, out_r=F0AAF0AA.
- Hold out_ready=0 for 5 cycles while in_valid=1 with new bytes -> outputs stable, no byte consumed, byte_cnt=0. Then out_ready=1 -> next block of FF×8 gives out_l=out_r=FFFFFFFF.
- Send 3 bytes, pulse clr coincident with a 4th byte, then send a full block -> byte_cnt=0 after clr, 4th byte dropped, result matches the fresh block only.
- Assert rst_n low asynchronously mid-cycle during HOLD -> out_valid, out_l, out_r, byte_cnt go to 0 immediately without a clock edge; in_ready=1 the cycle after release.
- Randomized: 1000 blocks with random in_valid/out_ready gaps -> each output equals the golden IP model; final permutation applied to each output returns the original block.
